// File: rtl/pwm_pkg.sv
// Shared widths and direction encoding for the PWM timebase.
package pwm_pkg;

    localparam int CNT_W = 16;
    localparam int PSC_W = 8;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/pwm_prescaler.sv
// Prescaler: emits a one-cycle tick every prescale+1 enabled cycles.
module pwm_prescaler #(
    parameter int PSC_W = pwm_pkg::PSC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             count_reset,
    input  logic [PSC_W-1:0] prescale,
    output logic             tick
);

    logic [PSC_W-1:0] psc_cnt;
    logic             psc_done;

    // >= rather than == so that lowering prescale below psc_cnt ticks at once
    assign psc_done = (psc_cnt >= prescale);
    assign tick     = en && !count_reset && psc_done;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst || count_reset) begin
            psc_cnt <= '0;
        end else if (en) begin
            psc_cnt <= psc_done ? '0 : psc_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_counter.sv
// PWM timebase: up/down count register with wrap detection and ovf pulse.
module pwm_counter #(
    parameter int CNT_W = pwm_pkg::CNT_W,
    parameter int PSC_W = pwm_pkg::PSC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             count_reset,
    input  logic             upnotdown,
    input  logic [CNT_W-1:0] period,
    input  logic [PSC_W-1:0] prescale,
    output logic [CNT_W-1:0] counter_val,
    output logic             ovf
);

    import pwm_pkg::*;

    logic tick;

    pwm_prescaler #(
        .PSC_W (PSC_W)
    ) u_prescaler (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .count_reset (count_reset),
        .prescale    (prescale),
        .tick        (tick)
    );

    // NOTE: reset is synchronous, so it lives inside the clocked branch and
    // is not in the sensitivity list.
    always_ff @(posedge clk) begin
        if (rst || count_reset) begin
            counter_val <= '0;
            ovf         <= 1'b0;
        end else if (!tick) begin
            ovf <= 1'b0;
        end else if (upnotdown == DIR_UP) begin
            // wrap decided by compare first, so the increment never carries out
            if (counter_val >= period) begin
                counter_val <= '0;
                ovf         <= 1'b1;
            end else begin
                counter_val <= counter_val + 1'b1;
                ovf         <= 1'b0;
            end
        end else begin
            if (counter_val == '0) begin
                counter_val <= period;
                ovf         <= 1'b1;
            end else if (counter_val > period) begin
                // out of range after a period write: clamp without a wrap event
                counter_val <= period;
                ovf         <= 1'b0;
            end else begin
                counter_val <= counter_val - 1'b1;
                ovf         <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_counter.sv
// Directed self-checking bench for pwm_counter.
module tb_pwm_counter;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        count_reset;
    logic        upnotdown;
    logic [15:0] period;
    logic [7:0]  prescale;
    logic [15:0] counter_val;
    logic        ovf;

    int total = 0;
    int bad   = 0;

    pwm_counter dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .count_reset (count_reset),
        .upnotdown   (upnotdown),
        .period      (period),
        .prescale    (prescale),
        .counter_val (counter_val),
        .ovf         (ovf)
    );

    always #5 clk = ~clk;

    // Advance n edges; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        en = 1'b1; count_reset = 1'b0; upnotdown = 1'b1;
        period = 16'h1234; prescale = 8'h00;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        total++;
        if (counter_val !== 16'h0000 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset: got cnt=%h ovf=%b want cnt=0000 ovf=0", counter_val, ovf);
        end
    endtask

    task automatic test_up_p3();
        logic [15:0] exp_c;
        en = 1'b1; count_reset = 1'b0; upnotdown = 1'b1;
        period = 16'd3; prescale = 8'd0;
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            step(1);
            exp_c = 16'(k % 4);
            total++;
            if (counter_val !== exp_c || ovf !== (k % 4 == 0)) begin
                bad++;
                $display("FAIL up_p3 k=%0d: got cnt=%h ovf=%b want cnt=%h ovf=%b",
                         k, counter_val, ovf, exp_c, (k % 4 == 0));
            end
        end
    endtask

    task automatic test_up_psc2();
        logic [15:0] exp_c;
        en = 1'b1; count_reset = 1'b0; upnotdown = 1'b1;
        period = 16'd2; prescale = 8'd2;
        do_reset();
        for (int k = 1; k <= 18; k++) begin
            step(1);
            exp_c = 16'((k / 3) % 3);
            total++;
            if (counter_val !== exp_c || ovf !== (k % 9 == 0)) begin
                bad++;
                $display("FAIL up_psc2 k=%0d: got cnt=%h ovf=%b want cnt=%h ovf=%b",
                         k, counter_val, ovf, exp_c, (k % 9 == 0));
            end
        end
    endtask

    task automatic test_down_and_hold();
        logic [15:0] exp_c [4] = '{16'd2, 16'd1, 16'd0, 16'd2};
        logic        exp_o [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        en = 1'b1; count_reset = 1'b0; upnotdown = 1'b0;
        period = 16'd2; prescale = 8'd0;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(1);
            total++;
            if (counter_val !== exp_c[k] || ovf !== exp_o[k]) begin
                bad++;
                $display("FAIL down k=%0d: got cnt=%h ovf=%b want cnt=%h ovf=%b",
                         k, counter_val, ovf, exp_c[k], exp_o[k]);
            end
        end
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(1);
            total++;
            if (counter_val !== 16'd2 || ovf !== 1'b0) begin
                bad++;
                $display("FAIL en_hold k=%0d: got cnt=%h ovf=%b want cnt=0002 ovf=0",
                         k, counter_val, ovf);
            end
        end
        en = 1'b1;
        step(1);
        total++;
        if (counter_val !== 16'd1 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL en_resume: got cnt=%h ovf=%b want cnt=0001 ovf=0", counter_val, ovf);
        end
    endtask

    task automatic test_period_write();
        en = 1'b1; count_reset = 1'b0; upnotdown = 1'b1;
        period = 16'hFFFF; prescale = 8'd0;
        do_reset();
        step(10);
        period = 16'h0005;
        step(1);
        total++;
        if (counter_val !== 16'h0000 || ovf !== 1'b1) begin
            bad++;
            $display("FAIL up_shrink: got cnt=%h ovf=%b want cnt=0000 ovf=1", counter_val, ovf);
        end
        period = 16'hFFFF;
        do_reset();
        step(10);
        period = 16'h0005; upnotdown = 1'b0;
        step(1);
        total++;
        if (counter_val !== 16'h0005 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL down_clamp: got cnt=%h ovf=%b want cnt=0005 ovf=0", counter_val, ovf);
        end
        step(1);
        total++;
        if (counter_val !== 16'h0004 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL down_after_clamp: got cnt=%h ovf=%b want cnt=0004 ovf=0", counter_val, ovf);
        end
    endtask

    task automatic test_count_reset();
        en = 1'b1; count_reset = 1'b0; upnotdown = 1'b1;
        period = 16'h0100; prescale = 8'd3;
        do_reset();
        step(4);
        total++;
        if (counter_val !== 16'd1) begin
            bad++;
            $display("FAIL cr_pre: got cnt=%h want cnt=0001", counter_val);
        end
        step(3);
        count_reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step(1);
            total++;
            if (counter_val !== 16'd0 || ovf !== 1'b0) begin
                bad++;
                $display("FAIL cr_hold k=%0d: got cnt=%h ovf=%b want cnt=0000 ovf=0",
                         k, counter_val, ovf);
            end
        end
        count_reset = 1'b0;
        step(3);
        total++;
        if (counter_val !== 16'd0) begin
            bad++;
            $display("FAIL cr_release3: got cnt=%h want cnt=0000", counter_val);
        end
        step(1);
        total++;
        if (counter_val !== 16'd1) begin
            bad++;
            $display("FAIL cr_release4: got cnt=%h want cnt=0001", counter_val);
        end
    endtask

    task automatic test_prescaler_edges();
        en = 1'b1; count_reset = 1'b0; upnotdown = 1'b1;
        period = 16'h0100; prescale = 8'd2;
        do_reset();
        step(1);
        en = 1'b0;
        step(3);
        en = 1'b1;
        step(1);
        total++;
        if (counter_val !== 16'd0) begin
            bad++;
            $display("FAIL psc_retain_a: got cnt=%h want cnt=0000", counter_val);
        end
        step(1);
        total++;
        if (counter_val !== 16'd1) begin
            bad++;
            $display("FAIL psc_retain_b: got cnt=%h want cnt=0001", counter_val);
        end
        prescale = 8'd3;
        step(2);
        prescale = 8'd0;
        step(1);
        total++;
        if (counter_val !== 16'd2) begin
            bad++;
            $display("FAIL psc_lower: got cnt=%h want cnt=0002", counter_val);
        end
    endtask

    task automatic test_boundaries();
        en = 1'b1; count_reset = 1'b0; upnotdown = 1'b1;
        period = 16'd0; prescale = 8'd0;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step(1);
            total++;
            if (counter_val !== 16'd0 || ovf !== 1'b1) begin
                bad++;
                $display("FAIL period0 k=%0d: got cnt=%h ovf=%b want cnt=0000 ovf=1",
                         k, counter_val, ovf);
            end
        end
        period = 16'hFFFF; upnotdown = 1'b0;
        do_reset();
        step(1);
        total++;
        if (counter_val !== 16'hFFFF || ovf !== 1'b1) begin
            bad++;
            $display("FAIL down_to_max: got cnt=%h ovf=%b want cnt=ffff ovf=1", counter_val, ovf);
        end
        upnotdown = 1'b1;
        step(1);
        total++;
        if (counter_val !== 16'h0000 || ovf !== 1'b1) begin
            bad++;
            $display("FAIL up_max_wrap: got cnt=%h ovf=%b want cnt=0000 ovf=1", counter_val, ovf);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; count_reset = 1'b0; upnotdown = 1'b1;
        period = '0; prescale = '0;
        step(2);
        test_reset();
        test_up_p3();
        test_up_psc2();
        test_down_and_hold();
        test_period_write();
        test_count_reset();
        test_prescaler_edges();
        test_boundaries();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
